dds_wave_core: RTL and testbench



---
 rtl/dds_wave_if.sv | 24 ++
 rtl/dds_wave_core.sv | 132 +++++++++++++
 tb/tb_dds_wave_core.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_wave_if.sv
// dds_wave_if: control inputs, ROM port and sample stream of the
// waveform core; master is the core side.
interface dds_wave_if #(
   parameter int PHASE_BIT = 12
);
   logic                        enable;
   logic [PHASE_BIT-2:0]        phase_M;
   logic [10:0]                 signal_A;
   logic [1:0]                  signal_shape;
   logic [PHASE_BIT-3:0]        rom_addr;
   logic [PHASE_BIT-2:0]        rom_data;
   logic signed [PHASE_BIT-1:0] sample_out;
   logic                        sample_valid;

   modport master (
      input  enable, phase_M, signal_A, signal_shape, rom_data,
      output rom_addr, sample_out, sample_valid
   );

   modport slave (
      output enable, phase_M, signal_A, signal_shape, rom_data,
      input  rom_addr, sample_out, sample_valid
   );
endinterface

// File: rtl/dds_wave_core.sv
// dds_wave_core: phase accumulator, quarter-wave ROM lookup and
// amplitude scaling into a signed sample stream.
module dds_wave_core #(
   parameter int ACC_W      = 20,
   parameter int PHASE_BIT  = 12,
   parameter int SAMPLE_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   dds_wave_if.master io
);

   localparam int IW    = PHASE_BIT - 2;
   localparam int PW    = PHASE_BIT + 11;
   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

   typedef struct packed {
      logic                 v;
      logic [PHASE_BIT-1:0] p;
      logic [1:0]           shape;
      logic [10:0]          a;
   } s0_t;

   typedef struct packed {
      logic          v;
      logic [1:0]    q;
      logic [IW-1:0] idx;
      logic [1:0]    shape;
      logic [10:0]   a;
   } sx_t;

   typedef struct packed {
      logic                        v;
      logic signed [PHASE_BIT-1:0] w;
      logic [10:0]                 a;
   } s3_t;

   logic [CNT_W-1:0]            cnt;
   logic [ACC_W-1:0]            acc;
   logic                        tick;
   s0_t                         s0;
   sx_t                         s1;
   sx_t                         s2;
   s3_t                         s3;
   logic [IW-1:0]               s0_idx;
   logic [IW-1:0]               s2_idx;
   logic [PHASE_BIT-2:0]        mag;
   logic signed [PHASE_BIT-1:0] mag_s;
   logic signed [PHASE_BIT-1:0] w;
   logic signed [PW-1:0]        w_ext;
   logic signed [PW-1:0]        a_ext;
   logic signed [PW-1:0]        prod;

   assign tick = io.enable && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (tick) begin
         cnt <= '0;
         acc <= acc + ACC_W'(io.phase_M);
      end else if (io.enable) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // inputs are captured only on ticks so in-flight samples keep them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= '0;
      end else begin
         s0.v <= tick;
         if (tick) begin
            s0.p     <= acc[ACC_W-1 -: PHASE_BIT];
            s0.shape <= io.signal_shape;
            s0.a     <= io.signal_A;
         end
      end
   end

   assign s0_idx = s0.p[PHASE_BIT-2] ? ~s0.p[IW-1:0] : s0.p[IW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1          <= '0;
         s2          <= '0;
         io.rom_addr <= '0;
      end else begin
         s1 <= '{v: s0.v, q: s0.p[PHASE_BIT-1 -: 2],
                 idx: s0.p[IW-1:0], shape: s0.shape, a: s0.a};
         io.rom_addr <= s0_idx;
         s2 <= s1;
      end
   end

   always_comb begin
      s2_idx = s2.q[0] ? ~s2.idx : s2.idx;
      mag    = '0;
      unique case (s2.shape)
         2'd0:    mag = io.rom_data;
         2'd1:    mag = {s2_idx, 1'b0};
         2'd2:    mag = '1;
         default: mag = '0;
      endcase
      mag_s = $signed({1'b0, mag});
      w     = '0;
      if (s2.shape != 2'd3) w = s2.q[1] ? -mag_s : mag_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s3 <= '0;
      else        s3 <= '{v: s2.v, w: w, a: s2.a};
   end

   // slicing the product at bit 11 is a flooring arithmetic shift
   assign w_ext = PW'($signed(s3.w));
   assign a_ext = PW'(s3.a);
   assign prod  = w_ext * a_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io.sample_out   <= '0;
         io.sample_valid <= 1'b0;
      end else begin
         io.sample_valid <= s3.v;
         if (s3.v) io.sample_out <= prod[11 +: PHASE_BIT];
      end
   end

endmodule

// File: tb/tb_dds_wave_core.sv
// tb_dds_wave_core: scoreboard bench for two core instances,
// one ticking every clock and one every fourth clock.
module tb_dds_wave_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   dds_wave_if #(.PHASE_BIT(12)) i1 ();
   dds_wave_if #(.PHASE_BIT(12)) i4 ();

   dds_wave_core #(.ACC_W(20), .PHASE_BIT(12), .SAMPLE_DIV(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (i1.master)
   );

   dds_wave_core #(.ACC_W(20), .PHASE_BIT(12), .SAMPLE_DIV(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (i4.master)
   );

   // ROM contents equal the address
   always @(posedge clk) begin
      i1.rom_data <= {1'b0, i1.rom_addr};
      i4.rom_data <= {1'b0, i4.rom_addr};
   end

   typedef struct {
      int idx;
      int due;
      int exp;
   } sb_t;

   sb_t q1[$];
   sb_t q4[$];
   int  cyc = 0;
   int  tk1 = 0;
   int  tk4 = 0;
   int  macc1 = 0;
   int  macc4 = 0;
   int  mcnt4 = 0;
   int  got1[int];
   int  got4[int];
   int  tcyc1[int];
   int  addr1[int];
   int  first_v1 = -1;
   int  vcnt4 = 0;
   int  tests = 0;
   int  fails = 0;

   function automatic int model(int p, int shape, int a);
      int q, idx, mag, w, pr;
      q   = (p >> 10) & 3;
      idx = p & 1023;
      if (q % 2 == 1) idx = 1023 - idx;
      case (shape)
         0:       mag = idx;
         1:       mag = 2 * idx;
         2:       mag = 2047;
         default: return 0;
      endcase
      w  = (q >= 2) ? -mag : mag;
      pr = w * a;
      return (pr >= 0) ? pr / 2048 : -((-pr + 2047) / 2048);
   endfunction

   function automatic int g1(int k);
      return got1.exists(k) ? got1[k] : -99999;
   endfunction

   function automatic int g4(int k);
      return got4.exists(k) ? got4[k] : -99999;
   endfunction

   function automatic int a1(int k);
      int c;
      c = tcyc1.exists(k) ? tcyc1[k] + 1 : -1;
      return addr1.exists(c) ? addr1[c] : -99999;
   endfunction

   task automatic chk(input string tag,
                      input logic signed [31:0] got,
                      input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // reference model on the rising edge, scoreboard on the falling
   always begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         macc1 = 0; macc4 = 0; mcnt4 = 0;
         tk1 = 0; tk4 = 0;
         q1.delete(); q4.delete();
         got1.delete(); got4.delete(); tcyc1.delete();
         first_v1 = -1;
         vcnt4 = 0;
      end else begin
         if (i1.enable) begin
            q1.push_back('{tk1, cyc + 4, model((macc1 >> 8) & 4095,
               int'(i1.signal_shape), int'(i1.signal_A))});
            tcyc1[tk1] = cyc;
            tk1++;
            macc1 = (macc1 + int'(i1.phase_M)) & 'hFFFFF;
         end
         if (i4.enable) begin
            if (mcnt4 == 3) begin
               q4.push_back('{tk4, cyc + 4, model((macc4 >> 8) & 4095,
                  int'(i4.signal_shape), int'(i4.signal_A))});
               tk4++;
               macc4 = (macc4 + int'(i4.phase_M)) & 'hFFFFF;
               mcnt4 = 0;
            end else begin
               mcnt4++;
            end
         end
      end
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_smp1", $signed(i1.sample_out), 0);
         chk("rst_vld1", i1.sample_valid, 0);
         chk("rst_smp4", $signed(i4.sample_out), 0);
         chk("rst_vld4", i4.sample_valid, 0);
      end else begin
         addr1[cyc] = int'(i1.rom_addr);
         if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("vld1", i1.sample_valid, 1);
            chk("smp1", $signed(i1.sample_out), q1[0].exp);
            got1[q1[0].idx] = int'($signed(i1.sample_out));
            if (first_v1 < 0 && i1.sample_valid) first_v1 = cyc;
            void'(q1.pop_front());
         end else begin
            chk("spur1", i1.sample_valid, 0);
         end
         if (i4.sample_valid) vcnt4++;
         if (q4.size() > 0 && q4[0].due == cyc) begin
            chk("vld4", i4.sample_valid, 1);
            chk("smp4", $signed(i4.sample_out), q4[0].exp);
            got4[q4[0].idx] = int'($signed(i4.sample_out));
            void'(q4.pop_front());
         end else begin
            chk("spur4", i4.sample_valid, 0);
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      int r, n, v0;
      i1.enable = 0; i1.phase_M = '0; i1.signal_A = '0;
      i1.signal_shape = '0;
      i4.enable = 0; i4.phase_M = '0; i4.signal_A = '0;
      i4.signal_shape = '0;
      clks(3);
      chk("rst_addr1", i1.rom_addr, 0);
      chk("rst_addr4", i4.rom_addr, 0);

      // triangle ramp and latency, tick every clock
      i1.signal_shape = 2'd1; i1.signal_A = 11'd2047;
      i1.phase_M = 11'd1024; i1.enable = 1;
      rst_n = 1; r = cyc;
      clks(1035);
      chk("first_valid", first_v1, r + 5);
      chk("tri_n0", g1(0), 0);
      chk("tri_n1", g1(1), 7);
      chk("tri_n2", g1(2), 15);
      chk("tri_p1024", g1(256), 2045);
      chk("tri_p2048", g1(512), 0);
      chk("tri_p2052", g1(513), -8);
      chk("tri_wrap", g1(1024), 0);

      // sine addressing: p = 5, 1029, 2053
      rst_n = 0; clks(2);
      i1.signal_shape = 2'd0; i1.phase_M = 11'd1280;
      rst_n = 1;
      clks(1);
      i1.phase_M = 11'd1024;
      clks(520);
      chk("sin_addr5", a1(1), 5);
      chk("sin_p5", g1(1), 4);
      chk("sin_addr1029", a1(257), 1018);
      chk("sin_p1029", g1(257), 1017);
      chk("sin_addr2053", a1(513), 5);
      chk("sin_p2053", g1(513), -5);

      // square, then silence from the next tick
      rst_n = 0; clks(2);
      i1.signal_shape = 2'd2; i1.signal_A = 11'd1024;
      rst_n = 1;
      clks(520);
      chk("sq_q0", g1(0), 1023);
      chk("sq_q1", g1(511), 1023);
      chk("sq_q2", g1(512), -1024);
      n = tk1;
      i1.signal_shape = 2'd3;
      clks(8);
      chk("sq_before", g1(n - 1), -1024);
      chk("sil_first", g1(n), 0);
      chk("sil_next", g1(n + 1), 0);

      // divider of four, hold and resume
      rst_n = 0; i1.enable = 0; clks(2);
      i4.signal_shape = 2'd1; i4.signal_A = 11'd2047;
      i4.phase_M = 11'd1024; i4.enable = 1;
      rst_n = 1;
      clks(40);
      chk("div_pulses", vcnt4, 9);
      n = tk4; v0 = vcnt4;
      i4.enable = 0;
      clks(10);
      chk("hold_inflight", (vcnt4 - v0 <= 1), 1);
      chk("hold_tail", g4(n - 1), (8 * (n - 1) * 2047) / 2048);
      i4.enable = 1;
      clks(20);
      chk("resume_phase", g4(n), (8 * n * 2047) / 2048);

      // amplitude change between ticks
      n = tk4;
      i4.signal_A = 11'd1024;
      clks(20);
      chk("amp_old", g4(n - 1), (8 * (n - 1) * 2047) / 2048);
      chk("amp_new", g4(n), 4 * n);

      // reset in the middle of a stream
      rst_n = 0; i4.enable = 0; clks(2);
      i1.signal_shape = 2'd1; i1.signal_A = 11'd2047;
      i1.phase_M = 11'd1024; i1.enable = 1;
      rst_n = 1;
      clks(10);
      chk("mid_vld_pre", i1.sample_valid, 1);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("mid_smp_clr", $signed(i1.sample_out), 0);
      chk("mid_vld_clr", i1.sample_valid, 0);
      clks(2);
      rst_n = 1; r = cyc;
      clks(8);
      chk("mid_first", first_v1, r + 5);
      chk("mid_p0", g1(0), 0);
      chk("mid_p4", g1(1), 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
